branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters. It sits beside the PC register in IF. Each cycle it predicts the next fetch PC from the current PC, and it is trained by the stage that resolves branches and jumps. It lets the pipeline redirect fetch speculatively instead of always fetching PC+4 and flushing on every taken branch.

## Interface
Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of table entries; power of two, at least 2.
- CTR_BITS, 2, width of each direction counter; at least 1.
- Derived (not overridable): IDX_BITS = log2(ENTRIES); TAG_BITS = XLEN-2-IDX_BITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- lookup_pc  in  XLEN  current fetch PC.
- pred_hit  out  1  lookup_pc matches a valid entry.
- pred_taken  out  1  prediction is taken.
- pred_next_pc  out  XLEN  predicted next fetch PC.
- upd_valid  in  1  one resolved control-flow instruction this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual target; meaningful only when upd_taken=1.
- upd_is_jump  in  1  the instruction is JAL/JALR (unconditional).
- upd_mispredict  in  1  the pipeline flushed for this instruction.
- flush_all  in  1  invalidate the whole table.
- perf_updates  out  XLEN  count of accepted updates.
- perf_mispredicts  out  XLEN  count of updates with upd_mispredict=1.

## Operation
- Address split:
  - index = pc[IDX_BITS+1:2]
  - tag = pc[XLEN-1:IDX_BITS+2]
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target (XLEN), ctr (CTR_BITS), jump.
- Lookup (combinational):
  - pred_hit = valid & (tag match).
  - pred_taken = pred_hit & (jump | ctr[CTR_BITS-1]).
  - pred_next_pc = pred_taken ? target : lookup_pc+4, with +4 wrapping modulo 2^XLEN.
- Update on a hit (valid & tag match at upd_pc's index):
  - jump=1 entry: ctr is held at the maximum value.
  - Otherwise ctr saturates: +1 if taken, capped at all-ones; -1 if not taken, floored at 0.
  - If taken, target <= upd_target.
  - jump <= upd_is_jump.
- Update on a miss:
  - upd_taken=1: allocate (overwrite) the entry. valid=1, tag, target, jump=upd_is_jump. ctr = all-ones if jump, else the weakly-taken value 1<<(CTR_BITS-1).
  - upd_taken=0: the table is unchanged.
- Perf counters: perf_updates +1 per upd_valid; perf_mispredicts +1 per upd_valid&upd_mispredict. Both saturate at all-ones and are not cleared by flush_all.
- Priority at a clock edge: rst > flush_all > update.
  - flush_all clears every valid bit; any simultaneous update to the table is dropped.
  - Perf counters still count an update that arrives with flush_all.
- Reset:
  - All valid bits = 0; ctr = 0; target/tag = 0.
  - perf_updates = 0; perf_mispredicts = 0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_next_pc=lookup_pc+4.

## Timing
- Lookup latency: 0 cycles, purely combinational from lookup_pc and current state.
- Update latency: 1 cycle. An update at edge N is visible to lookups from cycle N+1.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents (read-before-write).
- At most one update per cycle; there is no backpressure.
- Reset or flush_all asserted mid-operation takes effect at that edge; the following cycle's lookup misses.

## Structure
- Package bp_pkg holds:
  - the weakly-taken and saturated ctr constants, as functions of CTR_BITS;
  - the entry struct typedef {valid, tag, target, ctr, jump}.
- One sub-module: bp_sat_counter. It takes CTR_BITS-wide current value, inc/dec and force-max inputs, and produces the next value. It is combinational and instantiated once on the update path.
- The table is flops (not RAM) so flush_all and rst clear every entry in one cycle.

## Test plan
- Reset: assert rst 1 cycle, lookup_pc=0x100 → pred_hit=0, pred_next_pc=0x104, both perf counters 0.
- Allocate and train:
  - Update pc=0x40, taken, target=0x80, not jump → next cycle lookup 0x40 gives hit=1, taken=1, next_pc=0x80.
  - Two not-taken updates → taken=0, next_pc=0x44.
  - Then 3 taken updates → ctr saturates at 3; one not-taken still predicts taken.
- Alias: with ENTRIES=16, update pc=0x40 taken to 0x80, then pc=0x80 taken to 0x200 (same index, different tag) → lookup 0x40 misses, lookup 0x80 hits with 0x200.
- Not-taken miss: update pc=0x10, taken=0 → table unchanged; lookup 0x10 hit=0. perf_updates increments by 1.
- Jump: update pc=0x20, jump, target=0x300, then 5 not-taken updates → still predicts taken to 0x300.
- flush_all together with a taken update to pc=0x60 → all lookups miss next cycle; perf_updates still increments. Saturation check: preload perf counters (or XLEN=8 bench) past 255 → counter holds 0xFF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer.
// The counter constants are functions of the counter width, so each instance
// can derive them from its own CTR_BITS.
package bp_pkg;

  // Kind of table write chosen for the current update.
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_TRAIN,
    UPD_ALLOC
  } upd_kind_e;

  // Saturated counter value: all ones at the given width.
  function automatic int unsigned ctr_max(input int unsigned bits);
    return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
  endfunction

  // Weakly-taken counter value: only the MSB set.
  function automatic int unsigned ctr_weak(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, resolve-side training, and perf counter bundle.
// The master is the pipeline. The slave is the predictor.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] lookup_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_next_pc;

  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_is_jump;
  logic            upd_mispredict;
  logic            flush_all;

  logic [XLEN-1:0] perf_updates;
  logic [XLEN-1:0] perf_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_is_jump, upd_mispredict, flush_all,
    input  pred_hit, pred_taken, pred_next_pc, perf_updates, perf_mispredicts
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_is_jump, upd_mispredict, flush_all,
    output pred_hit, pred_taken, pred_next_pc, perf_updates, perf_mispredicts
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Next-value logic for one saturating direction counter.
// force_max_i pins the counter at all ones; this is used for unconditional jumps.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur_i,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic                force_max_i,
  output logic [CTR_BITS-1:0] next_o
);
  localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));

  // Saturating step: force, or increment / decrement within [0, max].
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    next_o = cur_i;
    if (force_max_i) begin
      next_o = CTR_MAX;
    end else if (inc_i && (cur_i != CTR_MAX)) begin
      next_o = cur_i + CTR_BITS'(1);
    end else if (dec_i && (cur_i != '0)) begin
      next_o = cur_i - CTR_BITS'(1);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Lookup is combinational and reads the state from before the clock edge.
// Training from the resolve stage takes effect at the next clock edge.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = XLEN - 2 - IDX_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_max(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(ctr_weak(CTR_BITS));

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
    logic                jump;
  } entry_t;

  entry_t table_q [ENTRIES];
  entry_t table_d [ENTRIES];

  logic [XLEN-1:0] perf_upd_q, perf_upd_d;
  logic [XLEN-1:0] perf_mis_q, perf_mis_d;

  // ---------------------------------------------------------------- lookup
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  entry_t              lk_entry;
  logic                lk_hit;
  logic                lk_taken;

  // Read the indexed entry and form the prediction.
  always_comb begin
    lk_idx   = bp.lookup_pc[IDX_BITS+1:2];
    lk_tag   = bp.lookup_pc[XLEN-1:IDX_BITS+2];
    lk_entry = table_q[lk_idx];
    lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
    lk_taken = lk_hit && (lk_entry.jump || lk_entry.ctr[CTR_BITS-1]);
  end

  assign bp.pred_hit     = lk_hit;
  assign bp.pred_taken   = lk_taken;
  assign bp.pred_next_pc = lk_taken ? lk_entry.target : (bp.lookup_pc + XLEN'(4));

  // ---------------------------------------------------------------- update
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  entry_t              upd_entry;
  logic                upd_hit;
  logic [CTR_BITS-1:0] ctr_next;
  upd_kind_e           upd_kind;

  // The low PC bits do not select an entry.
  logic unused_upd_pc_lsbs;
  assign unused_upd_pc_lsbs = ^bp.upd_pc[1:0];

  // Probe the entry that the resolved instruction maps to.
  always_comb begin
    upd_idx   = bp.upd_pc[IDX_BITS+1:2];
    upd_tag   = bp.upd_pc[XLEN-1:IDX_BITS+2];
    upd_entry = table_q[upd_idx];
    upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
  end

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_ctr (
    .cur_i       (upd_entry.ctr),
    .inc_i       (bp.upd_taken),
    .dec_i       (!bp.upd_taken),
    .force_max_i (upd_entry.jump),
    .next_o      (ctr_next)
  );

  // Decide between training, allocation, or no write. A flush drops the update.
  always_comb begin
    upd_kind = UPD_NONE;
    if (bp.upd_valid && !bp.flush_all) begin
      if (upd_hit) begin
        upd_kind = UPD_TRAIN;
      end else if (bp.upd_taken) begin
        upd_kind = UPD_ALLOC;
      end
    end
  end

  // Build the next table image: one entry write, or a clear of every valid bit.
  always_comb begin
    table_d = table_q;
    case (upd_kind)
      UPD_TRAIN: begin
        table_d[upd_idx].ctr  = ctr_next;
        table_d[upd_idx].jump = bp.upd_is_jump;
        if (bp.upd_taken) begin
          table_d[upd_idx].target = bp.upd_target;
        end
      end
      UPD_ALLOC: begin
        table_d[upd_idx].valid  = 1'b1;
        table_d[upd_idx].tag    = upd_tag;
        table_d[upd_idx].target = bp.upd_target;
        table_d[upd_idx].ctr    = bp.upd_is_jump ? CTR_MAX : CTR_WEAK;
        table_d[upd_idx].jump   = bp.upd_is_jump;
      end
      default: ;
    endcase
    if (bp.flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_d[i].valid = 1'b0;
      end
    end
  end

  // Saturating perf counters. A flush does not clear them, and they still
  // count an update that arrives together with a flush.
  always_comb begin
    perf_upd_d = perf_upd_q;
    perf_mis_d = perf_mis_q;
    if (bp.upd_valid && (perf_upd_q != '1)) begin
      perf_upd_d = perf_upd_q + XLEN'(1);
    end
    if (bp.upd_valid && bp.upd_mispredict && (perf_mis_q != '1)) begin
      perf_mis_d = perf_mis_q + XLEN'(1);
    end
  end

  assign bp.perf_updates     = perf_upd_q;
  assign bp.perf_mispredicts = perf_mis_q;

  // State register: the table and the perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is built from flops and every entry is reset, so a reset
      // leaves no stale valid bits. A RAM-based table could not be cleared this way.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
      end
      perf_upd_q <= '0;
      perf_mis_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values,
      // which is what makes lookups read-before-write.
      table_q    <= table_d;
      perf_upd_q <= perf_upd_d;
      perf_mis_q <= perf_mis_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor.
// The driver computes expected lookup results and perf values from a plain
// array model, then pushes them into a queue. A monitor on the falling edge
// pops the expected values and compares them with the DUT outputs.
// A second instance with XLEN=8 exercises perf counter saturation.
module tb_branch_predictor;
  localparam int ENT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32)) m_if ();
  branch_predictor_if #(.XLEN(8))  s_if ();

  branch_predictor #(.XLEN(32), .ENTRIES(ENT), .CTR_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (m_if)
  );

  branch_predictor #(.XLEN(8), .ENTRIES(ENT), .CTR_BITS(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bp  (s_if)
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] perf_upd;
    logic [31:0] perf_mis;
    logic [7:0]  s_upd;
    logic [7:0]  s_mis;
  } exp_t;

  exp_t exp_q[$];
  logic chk_valid;
  int   n_total = 0;
  int   n_pass  = 0;

  // ------------------------------------------------------------ reference model
  bit          m_valid  [ENT];
  logic [31:0] m_tag    [ENT];
  logic [31:0] m_target [ENT];
  int          m_ctr    [ENT];
  bit          m_jump   [ENT];
  longint      m_upd, m_mis;
  int          m_s_upd, m_s_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 0; m_jump[i] = 0;
    end
    m_upd = 0; m_mis = 0; m_s_upd = 0; m_s_mis = 0;
  endtask

  task automatic model_update(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] tgt, input logic uj, input logic um,
                              input logic fl);
    int  i;
    bit  hit;
    i   = idx_of(upc);
    hit = m_valid[i] && (m_tag[i] == tag_of(upc));
    if (uv) begin
      m_upd++;
      if (m_s_upd < 255) m_s_upd++;
      if (um) begin
        m_mis++;
        if (m_s_mis < 255) m_s_mis++;
      end
    end
    if (fl) begin
      for (int k = 0; k < ENT; k++) m_valid[k] = 0;
    end else if (uv && hit) begin
      if (m_jump[i]) m_ctr[i] = 3;
      else if (ut)   m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      else           m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      if (ut) m_target[i] = tgt;
      m_jump[i] = uj;
    end else if (uv && ut) begin
      m_valid[i] = 1; m_tag[i] = tag_of(upc); m_target[i] = tgt;
      m_ctr[i] = uj ? 3 : 2; m_jump[i] = uj;
    end
  endtask

  // ------------------------------------------------------------ checking
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: the driver raises chk_valid while a lookup result is being presented.
  always @(negedge clk) begin
    exp_t e;
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pred_hit",          {63'd0, m_if.pred_hit},   {63'd0, e.hit});
        check("pred_taken",        {63'd0, m_if.pred_taken}, {63'd0, e.taken});
        check("pred_next_pc",      {32'd0, m_if.pred_next_pc},     {32'd0, e.next_pc});
        check("perf_updates",      {32'd0, m_if.perf_updates},     {32'd0, e.perf_upd});
        check("perf_mispredicts",  {32'd0, m_if.perf_mispredicts}, {32'd0, e.perf_mis});
        check("small_perf_updates",     {56'd0, s_if.perf_updates},     {56'd0, e.s_upd});
        check("small_perf_mispredicts", {56'd0, s_if.perf_mispredicts}, {56'd0, e.s_mis});
      end
    end
  end

  // ------------------------------------------------------------ driver
  task automatic drive(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] tgt, input logic uj,
                       input logic um, input logic fl);
    m_if.lookup_pc = lk;   m_if.upd_valid = uv;   m_if.upd_pc = upc;
    m_if.upd_taken = ut;   m_if.upd_target = tgt; m_if.upd_is_jump = uj;
    m_if.upd_mispredict = um; m_if.flush_all = fl;
    s_if.lookup_pc = lk[7:0]; s_if.upd_valid = uv; s_if.upd_pc = upc[7:0];
    s_if.upd_taken = ut;   s_if.upd_target = tgt[7:0]; s_if.upd_is_jump = uj;
    s_if.upd_mispredict = um; s_if.flush_all = fl;
  endtask

  // One checked cycle: present the inputs, predict the lookup from the
  // pre-update model, then advance the model past the coming edge.
  task automatic cyc(input logic [31:0] lk, input logic uv = 0, input logic [31:0] upc = 0,
                     input logic ut = 0, input logic [31:0] tgt = 0, input logic uj = 0,
                     input logic um = 0, input logic fl = 0);
    exp_t e;
    int   i;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(lk, uv, upc, ut, tgt, uj, um, fl);
    i         = idx_of(lk);
    e.hit     = m_valid[i] && (m_tag[i] == tag_of(lk));
    e.taken   = e.hit && (m_jump[i] || (m_ctr[i] >= 2));
    e.next_pc = e.taken ? m_target[i] : lk + 32'd4;
    e.perf_upd = m_upd[31:0];
    e.perf_mis = m_mis[31:0];
    e.s_upd   = 8'(m_s_upd);
    e.s_mis   = 8'(m_s_mis);
    exp_q.push_back(e);
    chk_valid = 1'b1;
    model_update(uv, upc, ut, tgt, uj, um, fl);
  endtask

  // Hold rst for the next edge. The following cyc() call releases it.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    chk_valid = 1'b0;
    drive('0, 0, '0, 0, '0, 0, 0, 0);
    model_reset();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] tags [4];
    tags[0] = 32'd0; tags[1] = 32'd1; tags[2] = 32'd2; tags[3] = 32'h03FF_FFFF;
    return (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1'b1;
    chk_valid = 1'b0;
    drive('0, 0, '0, 0, '0, 0, 0, 0);
    model_reset();

    // Reset state.
    cyc(32'h100);
    // Allocate; the same-cycle lookup still misses.
    cyc(32'h40, 1, 32'h40, 1, 32'h80, 0, 1, 0);
    cyc(32'h40);
    // Two not-taken updates.
    cyc(32'h40, 1, 32'h40, 0, 32'h0, 0, 1, 0);
    cyc(32'h40, 1, 32'h40, 0, 32'h0, 0, 0, 0);
    cyc(32'h40);
    // Three taken updates saturate the counter; one not-taken update still predicts taken.
    for (int k = 0; k < 3; k++) cyc(32'h40, 1, 32'h40, 1, 32'h80, 0, 0, 0);
    cyc(32'h40, 1, 32'h40, 0, 32'h0, 0, 1, 0);
    cyc(32'h40);
    // Aliasing entry with the same index and a different tag.
    cyc(32'h80, 1, 32'h80, 1, 32'h200, 0, 0, 0);
    cyc(32'h40);
    cyc(32'h80);
    // A not-taken update that misses leaves the table unchanged.
    cyc(32'h10, 1, 32'h10, 0, 32'h0, 0, 0, 0);
    cyc(32'h10);
    // A jump entry stays taken through not-taken updates.
    cyc(32'h20, 1, 32'h20, 1, 32'h300, 1, 1, 0);
    for (int k = 0; k < 5; k++) cyc(32'h20, 1, 32'h20, 0, 32'h0, 1, 0, 0);
    cyc(32'h20);
    // A flush with a simultaneous taken update drops the update but counts it.
    cyc(32'h60, 1, 32'h60, 1, 32'h500, 0, 0, 1);
    cyc(32'h60);
    cyc(32'h20);
    cyc(32'h80);
    // PC+4 wraps.
    cyc(32'hFFFF_FFFC);

    // Randomized traffic over a small address pool, with one mid-run reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      cyc(rand_pc(), ($urandom_range(0, 9) < 8), rand_pc(), 1'($urandom_range(0, 1)),
          $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    // Drive the small instance's perf counters past saturation.
    for (int n = 0; n < 270; n++) begin
      cyc(rand_pc(), 1, rand_pc(), 0, 32'h0, 0, 1, 0);
    end
    cyc(32'h40);

    @(negedge clk); #1;
    chk_valid = 1'b0;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Bound on total runtime.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_total);
    $fatal(1, "watchdog expired");
  end
endmodule
